// File: rtl/jts16_vrom_pkg.sv
// rtl/jts16_vrom_pkg.sv - slot indices, arbiter states and slot width table for the video ROM arbiter
package jts16_vrom_pkg;

  localparam int NSLOTS = 6;

  localparam logic [2:0] SLOT_CHAR = 3'd0;
  localparam logic [2:0] SLOT_MAP1 = 3'd1;
  localparam logic [2:0] SLOT_SCR1 = 3'd2;
  localparam logic [2:0] SLOT_MAP2 = 3'd3;
  localparam logic [2:0] SLOT_SCR2 = 3'd4;
  localparam logic [2:0] SLOT_OBJ  = 3'd5;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    RD0,
    RD1,
    DONE
  } arb_state_t;

  // Set where the slot reads a low/high word pair per fetch.
  localparam logic [NSLOTS-1:0] SLOT_IS32 = 6'b010101;

  function automatic logic [NSLOTS-1:0] slot_onehot(input logic [2:0] s);
    return NSLOTS'(1) << s;
  endfunction

endpackage

// File: rtl/jts16_vrom_slot.sv
// rtl/jts16_vrom_slot.sv - one-entry cache for a single graphics ROM port
module jts16_vrom_slot #(
  parameter int AW   = 13,
  parameter bit IS32 = 1'b0,
  parameter int DW   = IS32 ? 32 : 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] addr,
  input  logic          cs,
  input  logic          in_flight,
  input  logic          grant,
  input  logic          wr_lo,
  input  logic          wr_hi,
  input  logic          done,
  input  logic [15:0]   din,
  output logic [DW-1:0] data,
  output logic          ok,
  output logic          pending
);

  logic [AW-1:0] cache_addr;
  logic          valid;
  logic [15:0]   lo_q;

  // The tag is captured at grant; valid only returns once the fetch is complete.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cache_addr <= '0;
      valid      <= 1'b0;
    end else if (grant) begin
      cache_addr <= addr;
      valid      <= 1'b0;
    end else if (done) begin
      valid <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lo_q <= '0;
    end else if (wr_lo) begin
      lo_q <= din;
    end
  end

  generate
    if (IS32) begin : g_w32
      logic [15:0] hi_q;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          hi_q <= '0;
        end else if (wr_hi) begin
          hi_q <= din;
        end
      end
      assign data = {hi_q, lo_q};
    end else begin : g_w16
      logic unused_hi;
      assign unused_hi = wr_hi;
      assign data      = lo_q;
    end
  endgenerate

  assign ok      = cs && valid && (addr == cache_addr);
  assign pending = cs && !ok && !in_flight;

endmodule

// File: rtl/jts16_vrom_arb.sv
// rtl/jts16_vrom_arb.sv - round-robin arbiter serving six cached video ROM ports from one SDRAM read channel
module jts16_vrom_arb
  import jts16_vrom_pkg::*;
#(
  parameter int            AW          = 22,
  parameter logic [AW-1:0] CHAR_OFFSET = '0,
  parameter logic [AW-1:0] MAP1_OFFSET = '0,
  parameter logic [AW-1:0] SCR1_OFFSET = '0,
  parameter logic [AW-1:0] MAP2_OFFSET = '0,
  parameter logic [AW-1:0] SCR2_OFFSET = '0,
  parameter logic [AW-1:0] OBJ_OFFSET  = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [12:0]   char_addr,
  output logic [31:0]   char_data,
  output logic          char_ok,
  input  logic [13:0]   map1_addr,
  output logic [15:0]   map1_data,
  output logic          map1_ok,
  input  logic [16:0]   scr1_addr,
  output logic [31:0]   scr1_data,
  output logic          scr1_ok,
  input  logic [13:0]   map2_addr,
  output logic [15:0]   map2_data,
  output logic          map2_ok,
  input  logic [16:0]   scr2_addr,
  output logic [31:0]   scr2_data,
  output logic          scr2_ok,
  input  logic          obj_cs,
  input  logic [17:0]   obj_addr,
  output logic [15:0]   obj_data,
  output logic          obj_ok,
  output logic [AW-1:0] sdram_addr,
  output logic          sdram_req,
  input  logic          sdram_ack,
  input  logic          sdram_rdy,
  input  logic [15:0]   sdram_din
);

  arb_state_t        state, next_state;
  logic [2:0]        cur_slot, last_served, grant_slot;
  logic              grant_found;
  logic [AW-1:0]     grant_addr;
  logic [NSLOTS-1:0] pending_v, grant_v, in_flight_v, wr_lo_v, wr_hi_v, done_v;

  // Search starts one past the last served slot so every slot waits at most five fetches.
  always_comb begin
    logic [3:0] idx;
    grant_found = 1'b0;
    grant_slot  = last_served;
    idx         = '0;
    for (int k = 1; k <= NSLOTS; k++) begin
      idx = {1'b0, last_served} + 4'(k);
      if (idx >= 4'(NSLOTS)) idx = idx - 4'(NSLOTS);
      if (!grant_found && pending_v[idx[2:0]]) begin
        grant_found = 1'b1;
        grant_slot  = idx[2:0];
      end
    end
  end

  always_comb begin
    case (grant_slot)
      SLOT_CHAR: grant_addr = CHAR_OFFSET + AW'({char_addr, 1'b0});
      SLOT_MAP1: grant_addr = MAP1_OFFSET + AW'(map1_addr);
      SLOT_SCR1: grant_addr = SCR1_OFFSET + AW'({scr1_addr, 1'b0});
      SLOT_MAP2: grant_addr = MAP2_OFFSET + AW'(map2_addr);
      SLOT_SCR2: grant_addr = SCR2_OFFSET + AW'({scr2_addr, 1'b0});
      default:   grant_addr = OBJ_OFFSET + AW'(obj_addr);
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state  = state;
    grant_v     = '0;
    wr_lo_v     = '0;
    wr_hi_v     = '0;
    done_v      = '0;
    in_flight_v = (state == IDLE) ? '0 : slot_onehot(cur_slot);
    case (state)
      IDLE: begin
        if (grant_found) begin
          grant_v    = slot_onehot(grant_slot);
          next_state = REQ;
        end
      end
      REQ: begin
        if (sdram_ack) next_state = RD0;
      end
      RD0: begin
        if (sdram_rdy) begin
          wr_lo_v    = slot_onehot(cur_slot);
          next_state = SLOT_IS32[cur_slot] ? RD1 : DONE;
        end
      end
      RD1: begin
        if (sdram_rdy) begin
          wr_hi_v    = slot_onehot(cur_slot);
          next_state = DONE;
        end
      end
      DONE: begin
        done_v     = slot_onehot(cur_slot);
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_slot    <= '0;
      last_served <= SLOT_OBJ;
      sdram_addr  <= '0;
      sdram_req   <= 1'b0;
    end else begin
      sdram_req <= (next_state == REQ);
      if (state == IDLE && grant_found) begin
        cur_slot   <= grant_slot;
        sdram_addr <= grant_addr;
      end
      if (state == DONE) last_served <= cur_slot;
    end
  end

  jts16_vrom_slot #(.AW(13), .IS32(1'b1)) u_char (
    .clk(clk), .rst(rst), .addr(char_addr), .cs(1'b1),
    .in_flight(in_flight_v[SLOT_CHAR]), .grant(grant_v[SLOT_CHAR]),
    .wr_lo(wr_lo_v[SLOT_CHAR]), .wr_hi(wr_hi_v[SLOT_CHAR]), .done(done_v[SLOT_CHAR]),
    .din(sdram_din), .data(char_data), .ok(char_ok), .pending(pending_v[SLOT_CHAR])
  );

  jts16_vrom_slot #(.AW(14), .IS32(1'b0)) u_map1 (
    .clk(clk), .rst(rst), .addr(map1_addr), .cs(1'b1),
    .in_flight(in_flight_v[SLOT_MAP1]), .grant(grant_v[SLOT_MAP1]),
    .wr_lo(wr_lo_v[SLOT_MAP1]), .wr_hi(wr_hi_v[SLOT_MAP1]), .done(done_v[SLOT_MAP1]),
    .din(sdram_din), .data(map1_data), .ok(map1_ok), .pending(pending_v[SLOT_MAP1])
  );

  jts16_vrom_slot #(.AW(17), .IS32(1'b1)) u_scr1 (
    .clk(clk), .rst(rst), .addr(scr1_addr), .cs(1'b1),
    .in_flight(in_flight_v[SLOT_SCR1]), .grant(grant_v[SLOT_SCR1]),
    .wr_lo(wr_lo_v[SLOT_SCR1]), .wr_hi(wr_hi_v[SLOT_SCR1]), .done(done_v[SLOT_SCR1]),
    .din(sdram_din), .data(scr1_data), .ok(scr1_ok), .pending(pending_v[SLOT_SCR1])
  );

  jts16_vrom_slot #(.AW(14), .IS32(1'b0)) u_map2 (
    .clk(clk), .rst(rst), .addr(map2_addr), .cs(1'b1),
    .in_flight(in_flight_v[SLOT_MAP2]), .grant(grant_v[SLOT_MAP2]),
    .wr_lo(wr_lo_v[SLOT_MAP2]), .wr_hi(wr_hi_v[SLOT_MAP2]), .done(done_v[SLOT_MAP2]),
    .din(sdram_din), .data(map2_data), .ok(map2_ok), .pending(pending_v[SLOT_MAP2])
  );

  jts16_vrom_slot #(.AW(17), .IS32(1'b1)) u_scr2 (
    .clk(clk), .rst(rst), .addr(scr2_addr), .cs(1'b1),
    .in_flight(in_flight_v[SLOT_SCR2]), .grant(grant_v[SLOT_SCR2]),
    .wr_lo(wr_lo_v[SLOT_SCR2]), .wr_hi(wr_hi_v[SLOT_SCR2]), .done(done_v[SLOT_SCR2]),
    .din(sdram_din), .data(scr2_data), .ok(scr2_ok), .pending(pending_v[SLOT_SCR2])
  );

  jts16_vrom_slot #(.AW(18), .IS32(1'b0)) u_obj (
    .clk(clk), .rst(rst), .addr(obj_addr), .cs(obj_cs),
    .in_flight(in_flight_v[SLOT_OBJ]), .grant(grant_v[SLOT_OBJ]),
    .wr_lo(wr_lo_v[SLOT_OBJ]), .wr_hi(wr_hi_v[SLOT_OBJ]), .done(done_v[SLOT_OBJ]),
    .din(sdram_din), .data(obj_data), .ok(obj_ok), .pending(pending_v[SLOT_OBJ])
  );

endmodule

// File: tb/tb_jts16_vrom_arb.sv
// tb/tb_jts16_vrom_arb.sv - scoreboard bench for the video ROM arbiter
module tb_jts16_vrom_arb;

  localparam int AW = 22;
  localparam logic [AW-1:0] CHAR_OFF = 22'h100000;
  localparam logic [AW-1:0] MAP1_OFF = 22'h200000;
  localparam logic [AW-1:0] SCR1_OFF = 22'h3FFFFE;
  localparam logic [AW-1:0] MAP2_OFF = 22'h210000;
  localparam logic [AW-1:0] SCR2_OFF = 22'h300000;
  localparam logic [AW-1:0] OBJ_OFF  = 22'h380000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [12:0] char_addr;
  logic [13:0] map1_addr, map2_addr;
  logic [16:0] scr1_addr, scr2_addr;
  logic [17:0] obj_addr;
  logic        obj_cs;
  logic [31:0] char_data, scr1_data, scr2_data;
  logic [15:0] map1_data, map2_data, obj_data;
  logic        char_ok, map1_ok, scr1_ok, map2_ok, scr2_ok, obj_ok;
  logic [AW-1:0] sdram_addr;
  logic        sdram_req, sdram_ack, sdram_rdy;
  logic [15:0] sdram_din;

  int n_checks = 0;
  int n_fail   = 0;
  logic [AW-1:0] exp_q[$];
  bit fixed_mode = 1'b1;
  int mphase = 0;

  wire [5:0]   ok_all   = {obj_ok, scr2_ok, map2_ok, scr1_ok, map1_ok, char_ok};
  wire [143:0] data_all = {char_data, map1_data, scr1_data, map2_data, scr2_data, obj_data};

  always #5 clk = ~clk;

  jts16_vrom_arb #(
    .AW(AW), .CHAR_OFFSET(CHAR_OFF), .MAP1_OFFSET(MAP1_OFF), .SCR1_OFFSET(SCR1_OFF),
    .MAP2_OFFSET(MAP2_OFF), .SCR2_OFFSET(SCR2_OFF), .OBJ_OFFSET(OBJ_OFF)
  ) dut (
    .clk(clk), .rst(rst),
    .char_addr(char_addr), .char_data(char_data), .char_ok(char_ok),
    .map1_addr(map1_addr), .map1_data(map1_data), .map1_ok(map1_ok),
    .scr1_addr(scr1_addr), .scr1_data(scr1_data), .scr1_ok(scr1_ok),
    .map2_addr(map2_addr), .map2_data(map2_data), .map2_ok(map2_ok),
    .scr2_addr(scr2_addr), .scr2_data(scr2_data), .scr2_ok(scr2_ok),
    .obj_cs(obj_cs), .obj_addr(obj_addr), .obj_data(obj_data), .obj_ok(obj_ok),
    .sdram_addr(sdram_addr), .sdram_req(sdram_req), .sdram_ack(sdram_ack),
    .sdram_rdy(sdram_rdy), .sdram_din(sdram_din)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] word_of(input logic [AW-1:0] a);
    return a[15:0] ^ {10'h0, a[21:16]} ^ 16'h5AC3;
  endfunction

  function automatic logic [31:0] exp32(input logic [AW-1:0] a);
    return {word_of(a + 22'd1), word_of(a)};
  endfunction

  function automatic logic [AW-1:0] a_char(input logic [12:0] a); return CHAR_OFF + AW'({a, 1'b0}); endfunction
  function automatic logic [AW-1:0] a_map1(input logic [13:0] a); return MAP1_OFF + AW'(a); endfunction
  function automatic logic [AW-1:0] a_scr1(input logic [16:0] a); return SCR1_OFF + AW'({a, 1'b0}); endfunction
  function automatic logic [AW-1:0] a_map2(input logic [13:0] a); return MAP2_OFF + AW'(a); endfunction
  function automatic logic [AW-1:0] a_scr2(input logic [16:0] a); return SCR2_OFF + AW'({a, 1'b0}); endfunction
  function automatic logic [AW-1:0] a_obj(input logic [17:0] a);  return OBJ_OFF + AW'(a); endfunction

  // SDRAM model: ack two cycles into the request, then two data words; abandons on reset.
  initial begin
    int mcnt;
    logic [15:0] w0, w1;
    sdram_ack = 1'b0; sdram_rdy = 1'b0; sdram_din = '0;
    mcnt = 0; w0 = '0; w1 = '0;
    forever begin
      @(negedge clk);
      sdram_ack = 1'b0;
      sdram_rdy = 1'b0;
      if (!rst) begin
        mphase = 0;
      end else begin
        case (mphase)
          0: if (sdram_req) begin
               check("req_expected", exp_q.size() != 0, 1);
               if (exp_q.size() != 0) check("grant_addr", sdram_addr, exp_q.pop_front());
               w0 = fixed_mode ? 16'h1111 : word_of(sdram_addr);
               w1 = fixed_mode ? 16'h2222 : word_of(sdram_addr + 22'd1);
               mcnt = 1; mphase = 1;
             end
          1: if (mcnt == 0) begin sdram_ack = 1'b1; mcnt = 1; mphase = 2; end else mcnt--;
          2: if (mcnt == 0) begin sdram_rdy = 1'b1; sdram_din = w0; mcnt = 1; mphase = 3; end else mcnt--;
          3: if (mcnt == 0) begin sdram_rdy = 1'b1; sdram_din = w1; mphase = 0; end else mcnt--;
          default: mphase = 0;
        endcase
      end
    end
  end

  task automatic set_all(input logic [12:0] c, input logic [13:0] m1, input logic [16:0] s1,
                         input logic [13:0] m2, input logic [16:0] s2, input logic [17:0] o);
    char_addr = c; map1_addr = m1; scr1_addr = s1; map2_addr = m2; scr2_addr = s2; obj_addr = o;
    exp_q.push_back(a_char(c));
    exp_q.push_back(a_map1(m1));
    exp_q.push_back(a_scr1(s1));
    exp_q.push_back(a_map2(m2));
    exp_q.push_back(a_scr2(s2));
    exp_q.push_back(a_obj(o));
  endtask

  task automatic drain();
    int i;
    for (i = 0; i < 400; i++) begin
      if (exp_q.size() == 0 && mphase == 0) break;
      @(negedge clk);
    end
    check("drain_in_time", i < 400, 1);
    repeat (6) @(negedge clk);
    #1;
  endtask

  task automatic check_all();
    check("ok_all", ok_all, 6'h3F);
    check("char_data", char_data, fixed_mode ? 32'h22221111 : exp32(a_char(char_addr)));
    check("map1_data", map1_data, fixed_mode ? 16'h1111 : word_of(a_map1(map1_addr)));
    check("scr1_data", scr1_data, fixed_mode ? 32'h22221111 : exp32(a_scr1(scr1_addr)));
    check("map2_data", map2_data, fixed_mode ? 16'h1111 : word_of(a_map2(map2_addr)));
    check("scr2_data", scr2_data, fixed_mode ? 32'h22221111 : exp32(a_scr2(scr2_addr)));
    check("obj_data", obj_data, fixed_mode ? 16'h1111 : word_of(a_obj(obj_addr)));
  endtask

  initial begin
    logic seen_ok;
    int i;
    char_addr = '0; map1_addr = '0; scr1_addr = '0; map2_addr = '0; scr2_addr = '0;
    obj_addr = '0; obj_cs = 1'b1; seen_ok = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    check("rst_req", sdram_req, 0);
    check("rst_addr", sdram_addr, 0);
    check("rst_ok", ok_all, 0);
    check("rst_data", |data_all, 0);

    // first batch: round robin from slot 0, scr1 offset wraps to word 0
    set_all(13'h10, 14'h3, 17'h1, 14'h7, 17'h2345, 18'h2ABCD);
    check("scr1_wrap_addr", a_scr1(scr1_addr), 22'h000000);
    @(negedge clk);
    rst = 1'b1;
    drain();
    check_all();
    repeat (20) @(negedge clk);
    #1;
    check("char_hold_ok", char_ok, 1);

    fixed_mode = 1'b0;
    set_all(13'h1ABC, 14'h2A5, 17'h1FFFF, 14'h3FFF, 17'h00400, 18'h3FFFF);
    drain();
    check_all();

    // char and scr2 miss together; char comes first after obj was last served
    char_addr = 13'h0777; scr2_addr = 17'h1C0DE;
    exp_q.push_back(a_char(char_addr));
    exp_q.push_back(a_scr2(scr2_addr));
    #1;
    check("char_ok_drop", char_ok, 0);
    drain();
    check("remiss_ok", ok_all, 6'h3F);
    check("remiss_char", char_data, exp32(a_char(char_addr)));
    check("remiss_scr2", scr2_data, exp32(a_scr2(scr2_addr)));

    obj_cs = 1'b0;
    #1;
    check("obj_ok_gated", obj_ok, 0);
    obj_addr = 18'h01234;
    repeat (20) @(negedge clk);
    #1;
    check("obj_ok_cs0", obj_ok, 0);
    obj_cs = 1'b1;
    exp_q.push_back(a_obj(obj_addr));
    drain();
    check("obj_ok_cs1", obj_ok, 1);
    check("obj_data_cs1", obj_data, word_of(a_obj(obj_addr)));

    // map1 address changes while its fetch is in RD0
    map1_addr = 14'h5;
    exp_q.push_back(a_map1(map1_addr));
    for (i = 0; i < 100; i++) begin
      @(negedge clk);
      #2;
      if (sdram_ack) break;
    end
    check("map1_ack_seen", i < 100, 1);
    @(negedge clk);
    #1;
    map1_addr = 14'h6;
    exp_q.push_back(a_map1(map1_addr));
    for (i = 0; i < 100 && exp_q.size() != 0; i++) begin
      @(negedge clk);
      #1;
      seen_ok = seen_ok | map1_ok;
    end
    check("map1_stale_ok", seen_ok, 0);
    drain();
    check("map1_new_ok", map1_ok, 1);
    check("map1_new_data", map1_data, word_of(a_map1(14'h6)));

    // reset lands in RD1 of a scr2 fetch
    scr2_addr = 17'h0BEEF;
    exp_q.push_back(a_scr2(scr2_addr));
    for (i = 0; i < 100; i++) begin
      @(negedge clk);
      #2;
      if (sdram_rdy) break;
    end
    check("scr2_rdy_seen", i < 100, 1);
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("midrst_req", sdram_req, 0);
    check("midrst_ok", ok_all, 0);
    check("midrst_data", |data_all, 0);
    set_all(char_addr, map1_addr, scr1_addr, map2_addr, scr2_addr, obj_addr);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    drain();
    check_all();

    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, checks %0d failures %0d", n_checks, n_fail);
    $fatal(1, "time limit");
  end

endmodule
